// File: rtl/ram_loader_pkg.sv
// Shared types and default sizing for the RAM loader.
package ram_loader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Loader bus: session control, upstream byte handshake, and the RAM write port.
interface ram_loader_if #(
    parameter int DATA_W = ram_loader_pkg::DATA_W_DEF,
    parameter int ADDR_W = ram_loader_pkg::ADDR_W_DEF
);

    logic              start;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] ram_din;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_prog;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    // The loader itself.
    modport master (
        input  start, abort, in_valid, in_data,
        output in_ready, ram_din, ram_addr, ram_prog, busy, done, checksum
    );

    // The CPU / upstream / RAM side.
    modport slave (
        output start, abort, in_valid, in_data,
        input  in_ready, ram_din, ram_addr, ram_prog, busy, done, checksum
    );

endinterface

// File: rtl/ram_loader_addr_cnt.sv
// RAM write-address counter: synchronous clear beats increment; tc flags the last location.
module ram_loader_addr_cnt
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    assign tc = &cnt;

endmodule

// File: rtl/ram_loader.sv
// RAM loader: writes one upstream byte per two cycles into all 2**ADDR_W RAM locations.
// Define RAM_LOADER_CHECKSUM_EN for a running byte checksum; otherwise checksum reads 0.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         n_rst,
    ram_loader_if.master bus
);

    state_t            state;
    logic [DATA_W-1:0] din_q;
    logic              prog_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr;
    logic              addr_tc;
    logic              in_session;
    logic              start_ok;
    logic              accept;

    assign in_session = (state == LOAD) || (state == WRITE);
    assign start_ok   = bus.start && ((state == IDLE) || (state == DONE));
    assign accept     = (state == LOAD) && bus.in_valid && !bus.abort;

    // Address advances as WRITE is left, so it stays put for the whole strobe cycle.
    ram_loader_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (start_ok || (in_session && bus.abort)),
        .inc   ((state == WRITE) && !bus.abort),
        .cnt   (addr),
        .tc    (addr_tc)
    );

    // NOTE: state and outputs are registers, so only <= here; a blocking write would
    // let later statements see the new value within the same edge and skew timing.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            din_q  <= '0;
            prog_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= LOAD;
                        done_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (accept) begin
                        din_q  <= bus.in_data;
                        prog_q <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    prog_q <= 1'b0;
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (addr_tc) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + bus.in_data;
        end
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.in_ready = (state == LOAD);
    assign bus.busy     = in_session;
    assign bus.ram_din  = din_q;
    assign bus.ram_addr = addr;
    assign bus.ram_prog = prog_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: random byte sessions, scoreboarded RAM writes, abort/start/reset corners.
module tb_ram_loader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic n_rst;

    ram_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wr_seen = 0;
    int wr_expected = 0;
    int sess_idx = 0;
    logic [DW-1:0] sess_sum = '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    logic [DW-1:0] ram     [DEPTH];   // the RAM the DUT writes into
    logic [DW-1:0] ref_mem [DEPTH];   // what that RAM ought to hold

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM behaviour: samples the strobe on the falling edge; every write is scoreboarded.
    always @(negedge clk) begin
        if (bus.ram_prog) begin
            wr_t e;
            wr_seen++;
            ram[bus.ram_addr] = bus.ram_din;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, no write expected (t=%0t)",
                         bus.ram_addr, bus.ram_din, $time);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.ram_addr), 32'(e.addr));
                check("write_data", 32'(bus.ram_din), 32'(e.data));
            end
        end
    end

    function automatic logic [DW-1:0] exp_checksum();
`ifdef RAM_LOADER_CHECKSUM_EN
        return sess_sum;
`else
        return '0;
`endif
    endfunction

    // Callers sit 1 time unit after a rising edge; every task returns aligned the same way.
    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_cyc = cyc;
        sess_idx  = 0;
        sess_sum  = '0;
    endtask

    // Offer one byte after `gap` idle cycles; the k-th accepted byte of a session lands at address k.
    task automatic send_byte(input logic [DW-1:0] d, input int gap, input bit expect_write);
        bit  accepted;
        wr_t e;
        accepted = 1'b0;
        bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (g == gap - 1 && gap >= 2) check("in_ready_held_in_gap", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 20 && !accepted; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                if (expect_write) begin
                    e.addr = AW'(sess_idx);
                    e.data = d;
                    exp_q.push_back(e);
                    ref_mem[sess_idx % DEPTH] = d;
                    wr_expected++;
                end
                sess_idx++;
                sess_sum = sess_sum + d;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_accept_timeout: byte 0x%0h not accepted within 20 cycles", d);
        end
    endtask

    task automatic wait_done(input int budget);
        int took;
        took = -1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (bus.done) begin
                took = cyc - start_cyc;
                break;
            end
        end
        if (took < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done not seen within %0d cycles", budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("%s_ram[%0d]", tag, i), 32'(ram[i]), 32'(ref_mem[i]));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_ram_prog"}, 32'(bus.ram_prog), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int took;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = DW'(8'hA0 + i);
            ref_mem[i] = DW'(8'hA0 + i);
        end

        // Reset takes effect before any clock edge.
        n_rst = 1'b1;
        #3 n_rst = 1'b0;
        #1;
        check_idle("reset");
        check("reset_ram_din",  32'(bus.ram_din),  32'd0);
        check("reset_checksum", 32'(bus.checksum), 32'd0);
        #8 n_rst = 1'b1;
        @(posedge clk); #1;

        // Abort in IDLE, even with a byte offered, changes nothing.
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("abort_in_idle");

        // Session 1: bytes 0x00..0x0F back to back.
        do_start();
        for (int i = 0; i < DEPTH; i++) send_byte(DW'(i), 0, 1'b1);
        took = cyc;
        wait_done(64);
        check("s1_done_latency", 32'(took + 1 - start_cyc), 32'd32);
        check("s1_done",     32'(bus.done),     32'd1);
        check("s1_busy",     32'(bus.busy),     32'd0);
        check("s1_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("s1_checksum", 32'(bus.checksum), 32'(exp_checksum()));
        check_ram("s1");

        // Abort in DONE is ignored.
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_in_done_done", 32'(bus.done), 32'd1);
        check("abort_in_done_busy", 32'(bus.busy), 32'd0);

        // Session 2 straight from DONE: all 0xFF.
        do_start();
        check("s2_done_cleared", 32'(bus.done),     32'd0);
        check("s2_busy",         32'(bus.busy),     32'd1);
        check("s2_addr_cleared", 32'(bus.ram_addr), 32'd0);
        check("s2_sum_cleared",  32'(bus.checksum), 32'd0);
        for (int i = 0; i < DEPTH; i++) send_byte(DW'(8'hFF), 0, 1'b1);
        wait_done(64);
        check("s2_done",     32'(bus.done),     32'd1);
        check("s2_checksum", 32'(bus.checksum), 32'(exp_checksum()));
        check_ram("s2");

        // Session 3: random bytes with 3-cycle gaps; a start at address 7 is ignored.
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 7) begin
                @(posedge clk); #1;
                check("s3_addr_before_start", 32'(bus.ram_addr), 32'(sess_idx));
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                check("s3_addr_after_start", 32'(bus.ram_addr), 32'(sess_idx));
                check("s3_busy_after_start", 32'(bus.busy),     32'd1);
            end
            send_byte(DW'($urandom), 3, 1'b1);
        end
        wait_done(200);
        check("s3_done",     32'(bus.done),     32'd1);
        check("s3_checksum", 32'(bus.checksum), 32'(exp_checksum()));
        check_ram("s3");

        // Session 4: abort during the fifth write; that write still lands, 5..15 untouched.
        do_start();
        for (int i = 0; i < 5; i++) send_byte(DW'($urandom), 0, 1'b1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_idle("s4_abort");
        repeat (2) @(posedge clk);
        #1;
        check_ram("s4");

        // Session 5: abort and in_valid together in LOAD; abort wins, no write.
        do_start();
        for (int i = 0; i < 2; i++) send_byte(DW'($urandom), 0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'($urandom);
        bus.abort    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        check_idle("s5_abort");
        repeat (3) @(posedge clk);
        #1;

        // Session 6: reset lands while the strobe is high; that write must never happen.
        do_start();
        for (int i = 0; i < 3; i++) send_byte(DW'($urandom), 0, 1'b1);
        send_byte(DW'($urandom), 0, 1'b0);
        check("s6_prog_before_reset", 32'(bus.ram_prog), 32'd1);
        n_rst = 1'b0;
        #1;
        check_idle("s6_reset");
        check("s6_reset_ram_din",  32'(bus.ram_din),  32'd0);
        check("s6_reset_checksum", 32'(bus.checksum), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("s6_after_release");
        check_ram("s6");

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("write_count",    32'(wr_seen),      32'(wr_expected));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
